t_block_assemble: RTL and testbench

Builds one Denavit-Hartenberg link transform from precomputed trigonometry and link lengths. It sits directly downstream of the sincos stage in the full_jacobian t_block: it consumes sin/cos of θ and α plus the link constants a and d. It emits the 12 non-trivial entries of the 4×4 matrix T, whose bottom row is fixed at 0 0 0 1. The six required products go through one shared 27-bit multiplier, time-multiplexed by a small FSM.

---
 rtl/t_block_pkg.sv | 47 ++++
 rtl/t_block_assemble_mult.sv | 30 +++
 rtl/t_block_assemble.sv | 147 ++++++++++++++
 tb/tb_t_block_assemble.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t_block_pkg.sv
// Shared types, constants and fixed-point helpers for the DH link-transform stage.
// Words are signed Q3.23 in 27 bits.
package t_block_pkg;

    localparam int FIX_W    = 27;
    localparam int FIX_FRAC = 23;

    typedef logic signed [FIX_W-1:0]   fix_t;
    typedef logic signed [2*FIX_W-1:0] prod_t;

    localparam fix_t FIX_ONE = 27'sh0800000;
    localparam fix_t FIX_MAX = 27'sh3FFFFFF;
    localparam fix_t FIX_MIN = 27'sh4000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    // Row-major positions of the twelve non-trivial matrix entries.
    typedef enum logic [3:0] {
        SLOT_T00, SLOT_T01, SLOT_T02, SLOT_T03,
        SLOT_T10, SLOT_T11, SLOT_T12, SLOT_T13,
        SLOT_T20, SLOT_T21, SLOT_T22, SLOT_T23
    } slot_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } tag_t;

    function automatic fix_t sat_neg(input fix_t x);
        return (x == FIX_MIN) ? FIX_MAX : -x;
    endfunction

    // Arithmetic shift floors toward -inf; anything outside the word range clamps.
    function automatic fix_t scale_sat(input prod_t p, input int unsigned frac);
        prod_t q;
        q = p >>> frac;
        if (q > prod_t'(FIX_MAX)) return FIX_MAX;
        if (q < prod_t'(FIX_MIN)) return FIX_MIN;
        return q[FIX_W-1:0];
    endfunction

endpackage

// File: rtl/t_block_assemble_mult.sv
// mult_27: signed W x W -> 2W multiplier, registered LAT stages deep, matching the
// pipeline behaviour of the lpm_mult configuration used elsewhere in the t_block.
module mult_27 #(
    parameter int W   = 27,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic signed [W-1:0]   dataa,
    input  logic signed [W-1:0]   datab,
    output logic signed [2*W-1:0] result
);

    logic signed [2*W-1:0] a_x;
    logic signed [2*W-1:0] b_x;
    logic signed [2*W-1:0] pipe [LAT];

    assign a_x = {{W{dataa[W-1]}}, dataa};
    assign b_x = {{W{datab[W-1]}}, datab};

    // NOTE: pure datapath pipeline with no reset; validity is tracked by the caller's tags.
    always_ff @(posedge clk) begin
        pipe[0] <= a_x * b_x;
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];

endmodule

// File: rtl/t_block_assemble.sv
// Assembles one DH link transform from sin/cos of theta/alpha and link constants,
// time-sharing a single pipelined multiplier across the six required products.
module t_block_assemble
    import t_block_pkg::*;
#(
    parameter int W        = FIX_W,
    parameter int FRAC     = FIX_FRAC,
    parameter int MULT_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] sin_t,
    input  logic signed [W-1:0] cos_t,
    input  logic signed [W-1:0] sin_a,
    input  logic signed [W-1:0] cos_a,
    input  logic signed [W-1:0] len_a,
    input  logic signed [W-1:0] len_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] t_out [0:11]
);

    state_e state, state_nxt;
    logic [2:0] issue_cnt;
    logic issue_en;
    logic accept;

    fix_t op_st, op_ct, op_sa, op_ca, op_a;
    fix_t mul_a, mul_b;
    prod_t mul_p;
    fix_t scaled;

    tag_t tag_q [MULT_LAT];
    tag_t tag_out;

    assign accept  = in_valid && in_ready;
    assign tag_out = tag_q[MULT_LAT-1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        issue_en  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                issue_en = 1'b1;
                if (issue_cnt == 3'd5) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (tag_out.vld && tag_out.idx == 3'd5) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state != S_ISSUE) issue_cnt <= '0;
        else                           issue_cnt <= issue_cnt + 3'd1;
    end

    // Operand registers hold only data, so they are loaded on acceptance and never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_st <= sin_t;
            op_ct <= cos_t;
            op_sa <= sin_a;
            op_ca <= cos_a;
            op_a  <= len_a;
        end
    end

    always_comb begin
        mul_a = op_st;
        mul_b = op_ca;
        case (issue_cnt)
            3'd1: begin mul_a = op_st; mul_b = op_sa; end
            3'd2: begin mul_a = op_ct; mul_b = op_ca; end
            3'd3: begin mul_a = op_ct; mul_b = op_sa; end
            3'd4: begin mul_a = op_a;  mul_b = op_ct; end
            3'd5: begin mul_a = op_a;  mul_b = op_st; end
            default: ;
        endcase
    end

    mult_27 #(.W(W), .LAT(MULT_LAT)) u_mult (
        .clk    (clk),
        .dataa  (mul_a),
        .datab  (mul_b),
        .result (mul_p)
    );

    assign scaled = scale_sat(mul_p, FRAC);

    // Tag pipeline mirrors the multiplier depth so each result finds its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{vld: issue_en, idx: issue_cnt};
            for (int i = 1; i < MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) t_out[i] <= '0;
        end else begin
            if (accept) begin
                t_out[SLOT_T00] <= cos_t;
                t_out[SLOT_T10] <= sin_t;
                t_out[SLOT_T20] <= '0;
                t_out[SLOT_T21] <= sin_a;
                t_out[SLOT_T22] <= cos_a;
                t_out[SLOT_T23] <= len_d;
            end
            if (tag_out.vld) begin
                case (tag_out.idx)
                    3'd0:    t_out[SLOT_T01] <= sat_neg(scaled);
                    3'd1:    t_out[SLOT_T02] <= scaled;
                    3'd2:    t_out[SLOT_T11] <= scaled;
                    3'd3:    t_out[SLOT_T12] <= sat_neg(scaled);
                    3'd4:    t_out[SLOT_T03] <= scaled;
                    3'd5:    t_out[SLOT_T13] <= scaled;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t_block_assemble.sv
// Randomised and directed bench for t_block_assemble against an integer-arithmetic
// model of the DH matrix with floor scaling and saturation.
module tb_t_block_assemble;
    import t_block_pkg::*;

    localparam int W        = 27;
    localparam int FRAC     = 23;
    localparam int MULT_LAT = 2;
    localparam int LATENCY  = 6 + MULT_LAT;
    localparam longint VMAX = (longint'(1) <<< (W-1)) - 1;
    localparam longint VMIN = -(longint'(1) <<< (W-1));
    localparam logic signed [W-1:0] ONE  = 27'sh0800000;
    localparam logic signed [W-1:0] RT2  = 27'sh05A8279;
    localparam logic signed [W-1:0] PMAX = 27'sh3FFFFFF;
    localparam logic signed [W-1:0] PMIN = 27'sh4000000;

    typedef struct {
        logic signed [W-1:0] st, ct, sa, ca, a, d;
    } bundle_t;

    logic clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic signed [W-1:0] sin_t, cos_t, sin_a, cos_a, len_a, len_d;
    logic signed [W-1:0] t_out [0:11];

    int n_checks = 0;
    int n_pass   = 0;
    longint expv [12];

    t_block_assemble #(.W(W), .FRAC(FRAC), .MULT_LAT(MULT_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sin_t     (sin_t),
        .cos_t     (cos_t),
        .sin_a     (sin_a),
        .cos_a     (cos_a),
        .len_a     (len_a),
        .len_d     (len_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .t_out     (t_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clampv(input longint v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic longint fmul(input longint x, input longint y);
        return clampv((x * y) >>> FRAC);
    endfunction

    function automatic longint fneg(input longint x);
        return clampv(-x);
    endfunction

    task automatic build_expected(input bundle_t b);
        expv[0]  = b.ct;
        expv[1]  = fneg(fmul(b.st, b.ca));
        expv[2]  = fmul(b.st, b.sa);
        expv[3]  = fmul(b.a, b.ct);
        expv[4]  = b.st;
        expv[5]  = fmul(b.ct, b.ca);
        expv[6]  = fneg(fmul(b.ct, b.sa));
        expv[7]  = fmul(b.a, b.st);
        expv[8]  = 0;
        expv[9]  = b.sa;
        expv[10] = b.ca;
        expv[11] = b.d;
    endtask

    function automatic int n_mismatch();
        int n = 0;
        for (int i = 0; i < 12; i++) if (longint'(t_out[i]) != expv[i]) n++;
        return n;
    endfunction

    function automatic int n_nonzero();
        int n = 0;
        for (int i = 0; i < 12; i++) if (t_out[i] != '0) n++;
        return n;
    endfunction

    function automatic logic signed [W-1:0] rnd_fix();
        case ($urandom_range(0, 7))
            0:       return PMAX;
            1:       return PMIN;
            2:       return ONE;
            3:       return -ONE;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive(input bundle_t b);
        sin_t = b.st; cos_t = b.ct; sin_a = b.sa; cos_a = b.ca;
        len_a = b.a;  len_d = b.d;
        in_valid = 1'b1;
    endtask

    task automatic accept();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input bundle_t b, input string tag);
        int n = 0;
        build_expected(b);
        while (!out_valid && n < 100) begin
            check({tag, "_busy_in_ready"}, in_ready, 0);
            tick();
            n++;
        end
        check({tag, "_latency"}, n, LATENCY);
        if (out_valid) begin
            for (int i = 0; i < 12; i++)
                check($sformatf("%s_T%0d%0d", tag, i / 4, i % 4), t_out[i], expv[i]);
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_post_out_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    task automatic run(input bundle_t b, input string tag);
        drive(b);
        accept();
        expect_result(b, tag);
        release_out(tag);
    endtask

    bundle_t b, b2;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sin_t = '0; cos_t = '0; sin_a = '0; cos_a = '0; len_a = '0; len_d = '0;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_t_out_nonzero", n_nonzero(), 0);
        reset = 1'b0;
        tick();

        b = '{st: '0, ct: ONE, sa: '0, ca: ONE, a: 27'sh1000000, d: ONE};
        run(b, "identity");
        b = '{st: ONE, ct: '0, sa: ONE, ca: '0, a: 27'sh0400000, d: 27'sh0123456};
        run(b, "right_angles");
        b = '{st: RT2, ct: RT2, sa: RT2, ca: RT2, a: ONE, d: '0};
        run(b, "diag45");
        b = '{st: 27'sh0200000, ct: ONE, sa: RT2, ca: -RT2, a: PMAX, d: PMIN};
        run(b, "a_max");
        b = '{st: '0, ct: PMIN, sa: PMIN, ca: PMIN, a: PMIN, d: PMAX};
        run(b, "min_sat");
        b = '{st: PMAX, ct: PMAX, sa: PMAX, ca: PMIN, a: PMAX, d: -ONE};
        run(b, "neg_of_min");

        // Output stall while a second bundle waits upstream.
        b  = '{st: RT2, ct: ONE, sa: -RT2, ca: RT2, a: 27'sh0C00000, d: 27'sh0300000};
        b2 = '{st: -ONE, ct: RT2, sa: ONE, ca: -RT2, a: 27'sh1800000, d: 27'sh7654321};
        out_ready = 1'b0;
        drive(b);
        accept();
        expect_result(b, "stall_first");
        drive(b2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_t_out", n_mismatch(), 0);
        end
        release_out("stall_first");
        accept();
        expect_result(b2, "stall_second");
        release_out("stall_second");

        // Reset in the middle of issue; stale products must never reach t_out.
        b = '{st: ONE, ct: ONE, sa: ONE, ca: ONE, a: ONE, d: ONE};
        drive(b);
        accept();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_t_out_nonzero", n_nonzero(), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_stale", n_nonzero(), 0);
        end
        b = '{st: RT2, ct: -RT2, sa: 27'sh0100000, ca: 27'sh07F0000, a: 27'sh2000000, d: 27'sh0000001};
        run(b, "after_rst");

        for (int r = 0; r < 30; r++) begin
            b = '{st: rnd_fix(), ct: rnd_fix(), sa: rnd_fix(), ca: rnd_fix(),
                  a: rnd_fix(), d: rnd_fix()};
            out_ready = ($urandom_range(0, 1) == 1);
            drive(b);
            accept();
            expect_result(b, $sformatf("rnd%0d", r));
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) begin
                    tick();
                    check("rnd_stall_out_valid", out_valid, 1);
                    check("rnd_stall_t_out", n_mismatch(), 0);
                end
            end
            release_out($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
